// File: rtl/trit_pack_stream.sv
// Streaming trit-to-byte packer: five trits per byte (t0 least significant, base 3), the last
// group of each frame is zero-padded, and any accepted illegal trit code raises a sticky flag.
module trit_pack_stream #(
   parameter int N_TRITS = 700,
   parameter int CNT_W   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_trit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_byte,
   output logic       out_last,
   output logic       err
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TRITS - 1);

   logic [2:0]       pos_reg, pos_next;
   logic [7:0]       pow_reg, pow_next;
   logic [7:0]       acc_reg, acc_next;
   logic [CNT_W-1:0] trit_cnt_reg, trit_cnt_next;
   logic             out_valid_reg, out_valid_next;
   logic [7:0]       out_byte_reg, out_byte_next;
   logic             out_last_reg, out_last_next;
   logic             err_reg, err_next;

   logic             accept;
   logic             illegal;
   logic [1:0]       trit_val;
   logic             frame_end;
   logic             closing;
   logic [7:0]       part [2];
   logic [7:0]       sum;

   // Register-only output buffer: accept only when the slot is empty or being drained now.
   assign in_ready  = ~rst & (~out_valid_reg | out_ready);
   assign accept    = in_valid & in_ready;
   assign illegal   = (in_trit == 2'b11);
   assign trit_val  = illegal ? 2'b00 : in_trit;
   assign frame_end = (trit_cnt_reg == LAST_IDX);
   assign closing   = (pos_reg == 3'd4) | frame_end;

   // v*pow as two shifted partial products (v is at most 2).
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_part
         assign part[gi] = trit_val[gi] ? (pow_reg << gi) : 8'd0;
      end
   endgenerate

   assign sum = acc_reg + part[0] + part[1];

   always_comb begin
      pos_next       = pos_reg;
      pow_next       = pow_reg;
      acc_next       = acc_reg;
      trit_cnt_next  = trit_cnt_reg;
      out_valid_next = out_valid_reg;
      out_byte_next  = out_byte_reg;
      out_last_next  = out_last_reg;
      err_next       = err_reg;

      if (out_valid_reg && out_ready) begin
         out_valid_next = 1'b0;
      end

      if (accept) begin
         if (illegal) begin
            err_next = 1'b1;
         end
         trit_cnt_next = frame_end ? '0 : trit_cnt_reg + 1'b1;
         if (closing) begin
            out_valid_next = 1'b1;
            out_byte_next  = sum;
            out_last_next  = frame_end;
            acc_next       = 8'd0;
            pow_next       = 8'd1;
            pos_next       = 3'd0;
         end else begin
            acc_next = sum;
            pow_next = (pow_reg << 1) + pow_reg;
            pos_next = pos_reg + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_reg       <= 3'd0;
         pow_reg       <= 8'd1;
         acc_reg       <= 8'd0;
         trit_cnt_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_byte_reg  <= 8'd0;
         out_last_reg  <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         pos_reg       <= pos_next;
         pow_reg       <= pow_next;
         acc_reg       <= acc_next;
         trit_cnt_reg  <= trit_cnt_next;
         out_valid_reg <= out_valid_next;
         out_byte_reg  <= out_byte_next;
         out_last_reg  <= out_last_next;
         err_reg       <= err_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_byte  = out_byte_reg;
   assign out_last  = out_last_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_trit_pack_stream.sv
// Scoreboard bench for trit_pack_stream: a 700-trit instance and a 7-trit instance are driven
// with directed and random trits; a base-3 reference model feeds per-instance expected queues.
module tb_trit_pack_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid [2];
   logic       in_ready [2];
   logic [1:0] in_trit  [2];
   logic       out_valid[2];
   logic       out_ready[2];
   logic [7:0] out_byte [2];
   logic       out_last [2];
   logic       err      [2];

   int checks = 0;
   int errors = 0;
   int exp_q0[$];
   int exp_q1[$];
   int grp[2][5];
   int gn[2];
   int fc[2];
   bit err_exp[2];
   int mode[2];       // 0: random out_ready, 1: always ready, 2: stalled
   int nbytes[2];
   int stall_waits;

   always #5 clk = ~clk;

   trit_pack_stream #(.N_TRITS(700), .CNT_W(10)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_trit(in_trit[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_byte(out_byte[0]),
      .out_last(out_last[0]), .err(err[0])
   );

   trit_pack_stream #(.N_TRITS(7), .CNT_W(3)) dut7 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_trit(in_trit[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_byte(out_byte[1]),
      .out_last(out_last[1]), .err(err[1])
   );

   function automatic void check(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endfunction

   function automatic int q_size(int k);
      return (k == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic int q_pop(int k);
      if (k == 0) return exp_q0.pop_front();
      return exp_q1.pop_front();
   endfunction

   // Reference: collect up to five trit values; a byte is their base-3 number, emitted when
   // five are collected or the frame is complete (absent high trits are simply not summed).
   function automatic void model_push(int k, logic [1:0] code);
      int v;
      int nt;
      int b;
      int p;
      int e;
      v  = (code == 2'b11) ? 0 : int'(code);
      nt = (k == 0) ? 700 : 7;
      b  = 0;
      p  = 1;
      if (code == 2'b11) err_exp[k] = 1'b1;
      grp[k][gn[k]] = v;
      gn[k]++;
      fc[k]++;
      if (gn[k] == 5 || fc[k] == nt) begin
         for (int i = 0; i < gn[k]; i++) begin
            b += grp[k][i] * p;
            p *= 3;
         end
         e = ((fc[k] == nt) ? 256 : 0) + b;
         if (k == 0) exp_q0.push_back(e);
         else        exp_q1.push_back(e);
         gn[k] = 0;
         if (fc[k] == nt) fc[k] = 0;
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         gn[k]      = 0;
         fc[k]      = 0;
         err_exp[k] = 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
   endfunction

   // Called at a falling edge; returns at the falling edge after the trit is accepted.
   task automatic send(input int k, input logic [1:0] code);
      int  waits;
      bit  took;
      waits = 0;
      took  = 1'b0;
      in_valid[k] = 1'b1;
      in_trit[k]  = code;
      while (!took) begin
         #4;
         took = in_ready[k];
         @(negedge clk);
         if (!took) begin
            waits++;
            stall_waits++;
            if (waits > 200) begin
               errors++;
               $display("FAIL send_timeout dut%0d: in_ready stayed 0, required 1", k);
               $display("Simulation finished: %0d checks, %0d errors", checks, errors);
               $fatal(1, "input handshake timeout");
            end
         end
      end
      in_valid[k] = 1'b0;
      model_push(k, code);
   endtask

   task automatic monitor(input int k);
      bit held;
      int held_val;
      int act;
      int act_v;
      held     = 1'b0;
      held_val = 0;
      forever begin
         @(negedge clk);
         out_ready[k] = (mode[k] == 1) ? 1'b1 :
                        (mode[k] == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
         #4;
         if (rst) begin
            held = 1'b0;
            continue;
         end
         act   = int'(out_last[k]) * 256 + int'(out_byte[k]);
         act_v = out_valid[k] ? act : -1;
         if (held) check("hold_stable", act_v, held_val);
         if (out_valid[k] && out_ready[k]) begin
            nbytes[k]++;
            if (q_size(k) == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte dut%0d: got %0d, required no byte", k, act);
            end else begin
               check((k == 0) ? "byte_last_n700" : "byte_last_n7", act, q_pop(k));
               check("err_flag", int'(err[k]), int'(err_exp[k]));
            end
         end
         held     = out_valid[k] && !out_ready[k];
         held_val = act;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q_size(0) != 0 || q_size(1) != 0 || out_valid[0] || out_valid[1]) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain_done", int'(t < 2000), 1);
   endtask

   initial begin
      int base;
      for (int k = 0; k < 2; k++) begin
         in_valid[k]  = 1'b0;
         in_trit[k]   = 2'b00;
         out_ready[k] = 1'b0;
         mode[k]      = 0;
         nbytes[k]    = 0;
      end
      model_reset();
      stall_waits = 0;
      fork
         monitor(0);
         monitor(1);
      join_none

      // Reset state, including in_ready forced low while rst is high
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
         check("rst_out_valid", int'(out_valid[k]), 0);
         check("rst_out_byte", int'(out_byte[k]), 0);
         check("rst_out_last", int'(out_last[k]), 0);
         check("rst_err", int'(err[k]), 0);
         check("rst_in_ready", int'(in_ready[k]), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1,2,0,1,2 -> 196; byte only after the fifth trit
      send(0, 2'd1); send(0, 2'd2); send(0, 2'd0); send(0, 2'd1);
      check("no_early_byte", int'(out_valid[0]), 0);
      send(0, 2'd2);
      check("latency_one_cycle", int'(out_valid[0]), 1);

      // Back-to-back with an always-ready sink: no input stalls
      mode[0] = 1;
      @(negedge clk);
      stall_waits = 0;
      repeat (5) send(0, 2'd2);
      repeat (5) send(0, 2'd0);
      check("no_stall_full_rate", stall_waits, 0);

      // Sink stalled: in_ready drops and the byte is held
      mode[0] = 2;
      @(negedge clk);
      fork
         repeat (10) send(0, 2'($urandom_range(0, 2)));
         begin
            repeat (6) @(negedge clk);
            #2;
            check("stall_in_ready", int'(in_ready[0]), 0);
            check("stall_out_valid", int'(out_valid[0]), 1);
            mode[0] = 0;
         end
      join

      // Illegal code counts as 0 and raises a sticky err
      send(0, 2'd1); send(0, 2'b11);
      check("err_set", int'(err[0]), 1);
      send(0, 2'd0); send(0, 2'd0); send(0, 2'd0);

      // Short frame: 2,2,2,2,2,1,1 -> 242 then padded 4 (last), then a fresh frame
      repeat (5) send(1, 2'd2);
      send(1, 2'd1); send(1, 2'd1);
      for (int i = 0; i < 14; i++) send(1, 2'($urandom_range(0, 3)));
      repeat (3) send(0, 2'd1);
      check("err_sticky", int'(err[0]), 1);
      drain();

      // Reset mid-group, then a full random frame
      repeat (3) send(0, 2'($urandom_range(0, 2)));
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("rst_clears_err", int'(err[0]), 0);
      check("rst_clears_valid", int'(out_valid[0]), 0);
      @(negedge clk);
      base = nbytes[0];
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 4) == 0) @(negedge clk);
         send(0, ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
      end
      drain();
      check("frame_byte_count", nbytes[0] - base, 140);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
